// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// Port A is the pipeline MEM stage, port B the loader/debug port.
module dmem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_RD_LAT = 1,
    parameter int PRIO_MODE  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (MEM_RD_LAT < 2) ? 1 : $clog2(MEM_RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_b_q, last_b_d;
    logic                sel_b_q, sel_b_d;
    logic                we_q, we_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic                busy_q, busy_d;
    logic                pick_b;
    logic                win_we;

    // Winner selection: a lone requester wins; on a tie fixed
    // priority favours A, round-robin favours the port not served last.
    always_comb begin
        pick_b = 1'b0;
        if (b_req && !a_req) begin
            pick_b = 1'b1;
        end else if (a_req && b_req && PRIO_MODE == 0) begin
            pick_b = !last_b_q;
        end
        win_we = pick_b ? b_we : a_we;
    end

    // Next-state and registered-output logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_b_d    = last_b_q;
        sel_b_d     = sel_b_q;
        we_d        = we_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    sel_b_d     = pick_b;
                    last_b_d    = pick_b;
                    we_d        = win_we;
                    mem_addr_d  = pick_b ? b_addr : a_addr;
                    mem_wdata_d = pick_b ? b_wdata : a_wdata;
                    cnt_d       = win_we ? CNT_W'(1) : CNT_W'(MEM_RD_LAT);
                    mem_write_d = win_we;
                    mem_read_d  = !win_we;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    if (sel_b_q) begin
                        b_ack_d = 1'b1;
                        if (!we_q) b_rdata_d = mem_rdata;
                    end else begin
                        a_ack_d = 1'b1;
                        if (!we_q) a_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    mem_read_d = !we_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_b_q    <= 1'b1;
            sel_b_q     <= 1'b0;
            we_q        <= 1'b0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_b_q    <= last_b_d;
            sel_b_q     <= sel_b_d;
            we_q        <= we_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
        end
    end

    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (round-robin L=1,
// fixed-priority L=1, round-robin L=3) against a transaction model.
module tb_dmem_arbiter;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        a_req [N];
    logic        a_we  [N];
    logic [15:0] a_addr [N];
    logic [15:0] a_wdata [N];
    logic        b_req [N];
    logic        b_we  [N];
    logic [15:0] b_addr [N];
    logic [15:0] b_wdata [N];
    logic        a_ack [N];
    logic        b_ack [N];
    logic [15:0] a_rdata [N];
    logic [15:0] b_rdata [N];
    logic [15:0] mem_addr [N];
    logic [15:0] mem_wdata [N];
    logic        mem_read [N];
    logic        mem_write [N];
    logic [15:0] mem_rdata [N];
    logic        busy [N];

    logic [15:0] salt = 16'h0;
    logic [15:0] dm [N][256];
    logic        dm_wr [N][256];

    int checks = 0;
    int failures = 0;

    // transaction-level reference model state
    int          cyc = 0;
    int          free_at [N];
    bit          act [N];
    int          t0 [N];
    bit          pb [N];
    bit          pwe [N];
    logic [15:0] pdata [N];
    bit          last_b [N];
    logic [15:0] ra_exp [N];
    logic [15:0] rb_exp [N];
    logic [15:0] ma_exp [N];
    logic [15:0] mw_exp [N];
    logic [15:0] mm [N][256];

    always #5 clk = ~clk;

    function automatic int lat_of(int g);
        return (g == 2) ? 3 : 1;
    endfunction

    function automatic bit prio_of(int g);
        return g == 1;
    endfunction

    function automatic logic [15:0] seed_val(int g, int a, logic [15:0] s);
        return 16'((a * 40503 + g * 977 + 11) & 16'hffff) ^ s;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        dmem_arbiter #(
            .ADDR_W(16), .DATA_W(16),
            .MEM_RD_LAT((g == 2) ? 3 : 1),
            .PRIO_MODE((g == 1) ? 1 : 0)
        ) u_dut (
            .clk(clk), .reset(reset),
            .a_req(a_req[g]), .a_we(a_we[g]),
            .a_addr(a_addr[g]), .a_wdata(a_wdata[g]),
            .a_ack(a_ack[g]), .a_rdata(a_rdata[g]),
            .b_req(b_req[g]), .b_we(b_we[g]),
            .b_addr(b_addr[g]), .b_wdata(b_wdata[g]),
            .b_ack(b_ack[g]), .b_rdata(b_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]),
            .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );

        // Data_Mem stand-in: combinational readout, write on clock edge
        assign mem_rdata[g] = dm_wr[g][mem_addr[g][7:0]] ?
            dm[g][mem_addr[g][7:0]] : seed_val(g, int'(mem_addr[g][7:0]), salt);

        always @(posedge clk) begin
            if (mem_write[g]) begin
                dm[g][mem_addr[g][7:0]] <= mem_wdata[g];
                dm_wr[g][mem_addr[g][7:0]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input int g,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h cyc=%0d",
                   tag, g, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            act[g] = 1'b0;
            free_at[g] = 0;
            last_b[g] = 1'b1;
            ra_exp[g] = '0;
            rb_exp[g] = '0;
            ma_exp[g] = '0;
            mw_exp[g] = '0;
        end
    endtask

    // One clock edge of the reference: completion then acceptance.
    task automatic model_edge();
        for (int g = 0; g < N; g++) begin
            int lat;
            bit wb;
            bit we;
            logic [15:0] ad;
            logic [15:0] wd;
            lat = pwe[g] ? 1 : lat_of(g);
            if (act[g] && cyc == t0[g] + lat && !pwe[g]) begin
                if (pb[g]) rb_exp[g] = pdata[g];
                else ra_exp[g] = pdata[g];
            end
            if (cyc >= free_at[g] && (a_req[g] || b_req[g])) begin
                if (a_req[g] && b_req[g])
                    wb = prio_of(g) ? 1'b0 : !last_b[g];
                else
                    wb = b_req[g];
                we = wb ? b_we[g] : a_we[g];
                ad = wb ? b_addr[g] : a_addr[g];
                wd = wb ? b_wdata[g] : a_wdata[g];
                act[g] = 1'b1;
                t0[g] = cyc;
                pb[g] = wb;
                pwe[g] = we;
                last_b[g] = wb;
                ma_exp[g] = ad;
                mw_exp[g] = wd;
                if (we) mm[g][ad[7:0]] = wd;
                else pdata[g] = mm[g][ad[7:0]];
                free_at[g] = cyc + (we ? 3 : 2 + lat_of(g));
            end
        end
    endtask

    task automatic compare_all();
        for (int g = 0; g < N; g++) begin
            int lat;
            int rel;
            lat = pwe[g] ? 1 : lat_of(g);
            rel = cyc - t0[g];
            chk("busy", g, busy[g], act[g] && rel <= lat);
            chk("mem_write", g, mem_write[g], act[g] && pwe[g] && rel == 0);
            chk("mem_read", g, mem_read[g], act[g] && !pwe[g] && rel < lat);
            chk("a_ack", g, a_ack[g], act[g] && !pb[g] && rel == lat);
            chk("b_ack", g, b_ack[g], act[g] && pb[g] && rel == lat);
            chk("a_rdata", g, a_rdata[g], ra_exp[g]);
            chk("b_rdata", g, b_rdata[g], rb_exp[g]);
            chk("mem_addr", g, mem_addr[g], ma_exp[g]);
            chk("mem_wdata", g, mem_wdata[g], mw_exp[g]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Called at a falling edge: reset asserted mid-cycle, outputs must clear at once.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        for (int g = 0; g < N; g++) begin
            chk("rst_a_ack", g, a_ack[g], 0);
            chk("rst_b_ack", g, b_ack[g], 0);
            chk("rst_a_rdata", g, a_rdata[g], 0);
            chk("rst_b_rdata", g, b_rdata[g], 0);
            chk("rst_mem_addr", g, mem_addr[g], 0);
            chk("rst_mem_wdata", g, mem_wdata[g], 0);
            chk("rst_mem_read", g, mem_read[g], 0);
            chk("rst_mem_write", g, mem_write[g], 0);
            chk("rst_busy", g, busy[g], 0);
        end
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        reset = 1'b0;
        compare_all();
    endtask

    task automatic new_a(int g);
        a_req[g] = 1'b1;
        a_we[g] = 1'($urandom_range(1));
        a_addr[g] = 16'($urandom_range(255));
        a_wdata[g] = 16'($urandom);
    endtask

    task automatic new_b(int g);
        b_req[g] = 1'b1;
        b_we[g] = 1'($urandom_range(1));
        b_addr[g] = 16'($urandom_range(255));
        b_wdata[g] = 16'($urandom);
    endtask

    // Random requesters: hold until ack, then drop or go back-to-back;
    // fields are scrambled while a transaction is in flight.
    task automatic drive_rand();
        for (int g = 0; g < N; g++) begin
            bit fly;
            fly = act[g] && cyc < t0[g] + (pwe[g] ? 1 : lat_of(g));
            if (a_req[g]) begin
                if (a_ack[g]) begin
                    if ($urandom_range(1) == 1) new_a(g);
                    else a_req[g] = 1'b0;
                end else if (fly && !pb[g] && $urandom_range(3) == 0) begin
                    a_addr[g] = 16'($urandom_range(255));
                    a_wdata[g] = 16'($urandom);
                    a_we[g] = 1'($urandom_range(1));
                end
            end else if ($urandom_range(2) == 0) begin
                new_a(g);
            end
            if (b_req[g]) begin
                if (b_ack[g]) begin
                    if ($urandom_range(1) == 1) new_b(g);
                    else b_req[g] = 1'b0;
                end else if (fly && pb[g] && $urandom_range(3) == 0) begin
                    b_addr[g] = 16'($urandom_range(255));
                    b_wdata[g] = 16'($urandom);
                    b_we[g] = 1'($urandom_range(1));
                end
            end else if ($urandom_range(2) == 0) begin
                new_b(g);
            end
        end
    endtask

    task automatic idle_inputs();
        for (int g = 0; g < N; g++) begin
            a_req[g] = 1'b0;
            b_req[g] = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        salt = 16'($urandom);
        for (int g = 0; g < N; g++) begin
            a_req[g] = 0; a_we[g] = 0; a_addr[g] = 0; a_wdata[g] = 0;
            b_req[g] = 0; b_we[g] = 0; b_addr[g] = 0; b_wdata[g] = 0;
            t0[g] = 0; pb[g] = 0; pwe[g] = 0; pdata[g] = 0;
            for (int i = 0; i < 256; i++) begin
                dm_wr[g][i] = 1'b0;
                dm[g][i] = '0;
                mm[g][i] = seed_val(g, i, salt);
            end
        end
        model_reset();
        @(negedge clk);
        do_reset();
        step();

        // A write 1<=5, then back-to-back read of 1 on the round-robin instance
        a_req[0] = 1; a_we[0] = 1; a_addr[0] = 16'd1; a_wdata[0] = 16'd5;
        step();
        chk("t2_mem_write", 0, mem_write[0], 1);
        chk("t2_mem_addr", 0, mem_addr[0], 16'd1);
        chk("t2_mem_wdata", 0, mem_wdata[0], 16'd5);
        chk("t2_early_ack", 0, a_ack[0], 0);
        step();
        chk("t2_wr_ack", 0, a_ack[0], 1);
        a_we[0] = 0; a_wdata[0] = 16'hdead;
        step();
        chk("t2_ack_pulse", 0, a_ack[0], 0);
        step();
        chk("t2_rd_strobe", 0, mem_read[0], 1);
        step();
        chk("t2_rd_ack", 0, a_ack[0], 1);
        chk("t2_rd_data", 0, a_rdata[0], 16'd5);
        a_req[0] = 0;
        step();
        step();
        chk("t2_rdata_hold", 0, a_rdata[0], 16'd5);

        // Round-robin tie from reset: A, B, A, B
        do_reset();
        a_req[0] = 1; a_we[0] = 0; a_addr[0] = 16'd1;
        b_req[0] = 1; b_we[0] = 0; b_addr[0] = 16'd50;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_order", 0, mem_addr[0], (k % 2 == 1) ? 16'd50 : 16'd1);
            step();
            chk("t3_ack", 0, (k % 2 == 1) ? b_ack[0] : a_ack[0], 1);
            step();
        end
        idle_inputs();
        step();

        // Fixed priority: continuous A starves B until A drops
        b_req[1] = 1; b_we[1] = 0; b_addr[1] = 16'd50;
        a_req[1] = 1; a_we[1] = 1; a_addr[1] = 16'd10;
        a_wdata[1] = 16'($urandom);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t4_a_wins", 1, mem_addr[1], 16'(10 + k));
            step();
            if (k < 2) begin
                a_addr[1] = 16'(11 + k);
                a_wdata[1] = 16'($urandom);
            end else begin
                a_req[1] = 0;
            end
            step();
        end
        step();
        chk("t4_b_served", 1, mem_addr[1], 16'd50);
        step();
        chk("t4_b_ack", 1, b_ack[1], 1);
        chk("t4_b_data", 1, b_rdata[1], mm[1][50]);
        b_req[1] = 0;
        step();

        // MEM_RD_LAT=3 read, then a read aborted by reset
        b_req[2] = 1; b_we[2] = 0; b_addr[2] = 16'd50;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_rd_strobe", 2, mem_read[2], 1);
            chk("t5_no_ack", 2, b_ack[2], 0);
        end
        step();
        chk("t5_rd_end", 2, mem_read[2], 0);
        chk("t5_b_ack", 2, b_ack[2], 1);
        chk("t5_b_data", 2, b_rdata[2], mm[2][50]);
        b_req[2] = 0;
        step();
        step();
        b_req[2] = 1;
        step();
        step();
        chk("t5_second_cycle", 2, mem_read[2], 1);
        b_req[2] = 0;
        do_reset();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (b_ack[2]) cnt++;
        end
        chk("t5_abort_no_ack", 2, cnt, 0);

        // Random traffic with a reset dropped in while requests are live
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 250; k++) begin
                drive_rand();
                step();
            end
            if (r < 2) do_reset();
        end
        idle_inputs();
        for (int k = 0; k < 8; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
